// File: rtl/bit_rate_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Produces packed BCD digits and a significant-digit count with a start/busy/done handshake.
module bit_rate_bcd_conv #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIGITS     = 10
) (
    input  logic                         clk_i,
    input  logic                         s_rst_n_i,
    input  logic                         start_i,
    input  logic [DATA_WIDTH-1:0]        bin_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [4*DIGITS-1:0]          bcd_o,
    output logic [$clog2(DIGITS+1)-1:0]  nz_digits_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned NZ_W  = $clog2(DIGITS + 1);

    // Decimal digits needed for the largest DATA_WIDTH-bit value.
    function automatic int unsigned dec_digits(input int unsigned w);
        logic [127:0] v;
        int unsigned  n;
        v = (128'(1) << w) - 128'(1);
        n = 1;
        while (v >= 128'd10) begin
            v = v / 128'd10;
            n = n + 1;
        end
        return n;
    endfunction

    if (DIGITS < dec_digits(DATA_WIDTH)) begin : g_bad_params
        $error("bit_rate_bcd_conv: DIGITS too small to hold 2**DATA_WIDTH-1");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_shreg;
    logic [BCD_W-1:0]        r_scratch;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic [BCD_W-1:0]        r_bcd;
    logic [NZ_W-1:0]         r_nz;

    logic [BCD_W-1:0]        w_adj;
    logic [BCD_W-1:0]        w_scratch_nxt;
    logic [DATA_WIDTH-1:0]   w_shreg_nxt;
    logic [NZ_W-1:0]         w_nz;

    // Add-3 on each digit >= 5, then shift the next binary bit into the scratch.
    always_comb begin
        w_adj = r_scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
        w_scratch_nxt = {w_adj[BCD_W-2:0], r_shreg[DATA_WIDTH-1]};
        w_shreg_nxt   = {r_shreg[DATA_WIDTH-2:0], 1'b0};
    end

    // Highest nonzero digit index + 1 of the final result; 1 when the value is zero.
    always_comb begin
        w_nz = NZ_W'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (w_scratch_nxt[4*i +: 4] != 4'd0) begin
                w_nz = NZ_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_nz      <= NZ_W'(1);
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_shreg   <= bin_i;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_scratch <= w_scratch_nxt;
                    r_shreg   <= w_shreg_nxt;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    // Final shift: publish the completed result only now.
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        r_bcd   <= w_scratch_nxt;
                        r_nz    <= w_nz;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign bcd_o       = r_bcd;
    assign nz_digits_o = r_nz;

endmodule

// File: tb/tb_bit_rate_bcd_conv.sv
// Directed and reference-model checks for bit_rate_bcd_conv at DATA_WIDTH=32, DIGITS=10.
module tb_bit_rate_bcd_conv;

    logic        clk;
    logic        s_rst_n;
    logic        start;
    logic [31:0] bin;
    logic        busy;
    logic        done;
    logic [39:0] bcd;
    logic [3:0]  nz;

    int n_checks;
    int n_fail;

    bit_rate_bcd_conv #(.DATA_WIDTH(32), .DIGITS(10)) dut (
        .clk_i      (clk),
        .s_rst_n_i  (s_rst_n),
        .start_i    (start),
        .bin_i      (bin),
        .busy_o     (busy),
        .done_o     (done),
        .bcd_o      (bcd),
        .nz_digits_o(nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] ref_bcd(input logic [31:0] v);
        logic [39:0] r;
        logic [31:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(t % 32'd10);
            t = t / 32'd10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_nz(input logic [31:0] v);
        logic [31:0] t;
        logic [3:0]  n;
        t = v;
        n = 4'd1;
        while (t >= 32'd10) begin
            t = t / 32'd10;
            n = n + 4'd1;
        end
        return n;
    endfunction

    // Pulse start for one edge; caller is just after a posedge with the DUT idle.
    task automatic kick(input logic [31:0] v);
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busy_cnt, output bit timed_out);
        cycles    = 0;
        busy_cnt  = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            cycles++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        start   = 1'b0;
        bin     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (bcd !== 40'h0) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0", bcd); end
        n_checks++;
        if (nz !== 4'd1) begin n_fail++; $display("FAIL reset_nz: got %0d expected 1", nz); end
        s_rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int cyc, bc;
        bit to;
        kick(32'd0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_start: got %b expected 1", busy); end
        wait_done(cyc, bc, to);
        n_checks++;
        if (to || cyc != 32) begin n_fail++; $display("FAIL zero_latency: got %0d expected 32 (timeout=%0d)", cyc, to); end
        n_checks++;
        if (bcd !== 40'h0) begin n_fail++; $display("FAIL zero_bcd: got %h expected 0", bcd); end
        n_checks++;
        if (nz !== 4'd1) begin n_fail++; $display("FAIL zero_nz: got %0d expected 1", nz); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", done); end
    endtask

    task automatic test_max();
        int cyc, bc;
        bit to;
        kick(32'hFFFF_FFFF);
        wait_done(cyc, bc, to);
        n_checks++;
        if (to || cyc != 32) begin n_fail++; $display("FAIL max_latency: got %0d expected 32 (timeout=%0d)", cyc, to); end
        n_checks++;
        if (bc + 1 != 32) begin n_fail++; $display("FAIL max_busy_cycles: got %0d expected 32", bc + 1); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL max_busy_end: got %b expected 0", busy); end
        n_checks++;
        if (bcd !== 40'h42_9496_7295) begin n_fail++; $display("FAIL max_bcd: got %h expected 4294967295", bcd); end
        n_checks++;
        if (nz !== 4'd10) begin n_fail++; $display("FAIL max_nz: got %0d expected 10", nz); end
    endtask

    task automatic test_ignore_start();
        int cyc, bc, extra_done;
        bit to;
        kick(32'd1000);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1;
        bin   = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bc, to);
        n_checks++;
        if (to || cyc != 27) begin n_fail++; $display("FAIL ign_latency: got %0d expected 27 (timeout=%0d)", cyc, to); end
        n_checks++;
        if (bcd !== 40'h1000) begin n_fail++; $display("FAIL ign_bcd: got %h expected 1000", bcd); end
        n_checks++;
        if (nz !== 4'd4) begin n_fail++; $display("FAIL ign_nz: got %0d expected 4", nz); end
        extra_done = 0;
        bc = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra_done++;
            if (busy) bc++;
        end
        n_checks++;
        if (extra_done != 0 || bc != 0) begin
            n_fail++;
            $display("FAIL ign_no_queue: got done=%0d busy=%0d expected 0 0", extra_done, bc);
        end
        n_checks++;
        if (bcd !== 40'h1000) begin n_fail++; $display("FAIL ign_hold: got %h expected 1000", bcd); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        bit to;
        start = 1'b1;
        bin   = 32'd99;
        @(posedge clk); #1;
        wait_done(cyc, bc, to);
        n_checks++;
        if (to || cyc != 32) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected 32 (timeout=%0d)", cyc, to); end
        n_checks++;
        if (bcd !== 40'h99) begin n_fail++; $display("FAIL b2b_bcd1: got %h expected 99", bcd); end
        n_checks++;
        if (nz !== 4'd2) begin n_fail++; $display("FAIL b2b_nz1: got %0d expected 2", nz); end
        bin = 32'd100;
        wait_done(cyc, bc, to);
        start = 1'b0;
        n_checks++;
        if (to || cyc != 33) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 33 (timeout=%0d)", cyc, to); end
        n_checks++;
        if (bcd !== 40'h100) begin n_fail++; $display("FAIL b2b_bcd2: got %h expected 100", bcd); end
        n_checks++;
        if (nz !== 4'd3) begin n_fail++; $display("FAIL b2b_nz2: got %0d expected 3", nz); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc, bc, seen_done;
        bit to;
        kick(32'd12345678);
        repeat (9) begin @(posedge clk); #1; end
        s_rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++;
        if (bcd !== 40'h0) begin n_fail++; $display("FAIL rstmid_bcd: got %h expected 0", bcd); end
        n_checks++;
        if (nz !== 4'd1) begin n_fail++; $display("FAIL rstmid_nz: got %0d expected 1", nz); end
        s_rst_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin n_fail++; $display("FAIL rstmid_aborted: got %0d active cycles expected 0", seen_done); end
        kick(32'd12345678);
        wait_done(cyc, bc, to);
        n_checks++;
        if (to || cyc != 32) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 32 (timeout=%0d)", cyc, to); end
        n_checks++;
        if (bcd !== 40'h12_3456_78 && bcd !== 40'h1234_5678) begin
            n_fail++; $display("FAIL rstmid_bcd2: got %h expected 12345678", bcd);
        end
        n_checks++;
        if (nz !== 4'd8) begin n_fail++; $display("FAIL rstmid_nz2: got %0d expected 8", nz); end
    endtask

    task automatic test_random();
        logic [31:0] vals [4];
        logic [31:0] v;
        int cyc, bc;
        bit to;
        vals[0] = 32'd9;
        vals[1] = 32'd10;
        vals[2] = 32'd99999;
        vals[3] = 32'h8000_0000;
        for (int i = 0; i < 124; i++) begin
            if (i < 4)       v = vals[i];
            else if (i < 40) v = 32'($urandom_range(0, 20000));
            else             v = $urandom;
            kick(v);
            wait_done(cyc, bc, to);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL rand_timeout: value %0d got no done expected done", v); end
            n_checks++;
            if (bcd !== ref_bcd(v)) begin
                n_fail++; $display("FAIL rand_bcd: value %0d got %h expected %h", v, bcd, ref_bcd(v));
            end
            n_checks++;
            if (nz !== ref_nz(v)) begin
                n_fail++; $display("FAIL rand_nz: value %0d got %0d expected %0d", v, nz, ref_nz(v));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_zero();
        test_max();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
